// File: rtl/board_io_ctl.sv
// board_io_ctl -- board-level housekeeping between FPGA pins and the mcu core.
//   * Reset sequencer: sys_rst_n releases once PLL lock and the board reset pin
//     have both been stable high for RST_HOLD clocks.
//   * Switch debouncers with single-cycle press pulses.
//   * LED drivers with per-LED mode/duty config: direct, PWM, blink, blink-PWM.
//     While sys_rst_n is low all LEDs are lit as a lamp test.
// Ports:
//   clk, rst           system clock, async active-high reset
//   pll_locked         PLL lock (async)
//   ext_rst_n          raw board reset pin (async, active-low)
//   sw_raw[NSW]        raw button pins (async)
//   sw_db[NSW]         debounced level, 1 = pressed
//   sw_press[NSW]      one-clock pulse when sw_db rises
//   led_src[NLED]      direct-mode LED sources
//   wr_en/wr_addr/wr_data  LED config write: wr_data = {mode[1:0], duty}
//   led_out[NLED]      registered LED drive
//   sys_rst_n          synchronous active-low reset to the mcu
module board_io_ctl #(
    parameter int NSW        = 4,
    parameter int NLED       = 8,
    parameter int SW_ACT_LOW = 1,
    parameter int DB_BITS    = 16,
    parameter int RST_HOLD   = 1024,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  ext_rst_n,
    input  logic [NSW-1:0]        sw_raw,
    output logic [NSW-1:0]        sw_db,
    output logic [NSW-1:0]        sw_press,
    input  logic [NLED-1:0]       led_src,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [PWM_BITS+1:0]   wr_data,
    output logic [NLED-1:0]       led_out,
    output logic                  sys_rst_n
);

    localparam int HW = (RST_HOLD > 2) ? $clog2(RST_HOLD) : 1;

    typedef enum logic {ST_HOLD, ST_RUN} rst_state_t;
    typedef enum logic [1:0] {M_DIRECT, M_PWM, M_BLINK, M_BLINK_PWM} led_mode_t;

    // ---------------- reset sequencer ----------------
    logic [1:0]    pll_sync, ext_sync;
    logic          ok;
    rst_state_t    state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_sync <= '0;
            ext_sync <= '0;
            state    <= ST_HOLD;
            hold_cnt <= '0;
        end else begin
            pll_sync <= {pll_sync[0], pll_locked};
            ext_sync <= {ext_sync[0], ext_rst_n};
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    assign ok = pll_sync[1] & ext_sync[1];

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            ST_HOLD: begin
                if (!ok) begin
                    hold_cnt_nxt = '0;
                end else if (hold_cnt == HW'(RST_HOLD - 1)) begin
                    state_nxt    = ST_RUN;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!ok) begin
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_HOLD;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    assign sys_rst_n = (state == ST_RUN);

    // ---------------- switch debouncers ----------------
    logic [NSW-1:0]     sw_s1, sw_s2, sw_sync;
    logic [DB_BITS-1:0] db_cnt [NSW];

    assign sw_sync = (SW_ACT_LOW != 0) ? ~sw_s2 : sw_s2;

    // The press pulse is registered alongside the sw_db update, so it is high
    // in exactly the first cycle sw_db reads 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            sw_db    <= '0;
            sw_press <= '0;
            for (int unsigned i = 0; i < NSW; i++) db_cnt[i] <= '0;
        end else begin
            sw_s1    <= sw_raw;
            sw_s2    <= sw_s1;
            sw_press <= '0;
            for (int unsigned i = 0; i < NSW; i++) begin
                if (sw_sync[i] == sw_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (&db_cnt[i]) begin
                    sw_db[i]    <= sw_sync[i];
                    sw_press[i] <= sw_sync[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ---------------- LED config and drive ----------------
    led_mode_t           led_mode [NLED];
    logic [PWM_BITS-1:0] led_duty [NLED];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic [NLED-1:0]     led_nxt;

    // Address decode by comparison per LED, so addresses >= NLED match nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NLED; i++) begin
                led_mode[i] <= M_DIRECT;
                led_duty[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NLED; i++) begin
                if (wr_addr == 4'(i)) begin
                    led_mode[i] <= led_mode_t'(wr_data[PWM_BITS+1:PWM_BITS]);
                    led_duty[i] <= wr_data[PWM_BITS-1:0];
                end
            end
        end
    end

    always_comb begin
        led_nxt = '0;
        for (int unsigned i = 0; i < NLED; i++) begin
            case (led_mode[i])
                M_DIRECT:    led_nxt[i] = led_src[i];
                M_PWM:       led_nxt[i] = (pwm_cnt < led_duty[i]);
                M_BLINK:     led_nxt[i] = blink_cnt[BLINK_BITS-1];
                M_BLINK_PWM: led_nxt[i] = blink_cnt[BLINK_BITS-1] & (pwm_cnt < led_duty[i]);
                default:     led_nxt[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            led_out   <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            led_out   <= sys_rst_n ? led_nxt : '1;
        end
    end

endmodule

// File: tb/tb_board_io_ctl.sv
module tb_board_io_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       ext_rst_n;
    logic [3:0] sw_raw;
    logic [3:0] sw_db;
    logic [3:0] sw_press;
    logic [7:0] led_src;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [9:0] wr_data;
    logic [7:0] led_out;
    logic       sys_rst_n;

    int errors = 0;
    int checks = 0;

    board_io_ctl #(
        .NSW(4), .NLED(8), .SW_ACT_LOW(1), .DB_BITS(4),
        .RST_HOLD(16), .PWM_BITS(8), .BLINK_BITS(6)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .ext_rst_n(ext_rst_n),
        .sw_raw(sw_raw), .sw_db(sw_db), .sw_press(sw_press),
        .led_src(led_src), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .led_out(led_out), .sys_rst_n(sys_rst_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [1:0] m, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = {m, d};
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // n = edges after rst deassert until sys_rst_n seen high (first tick included)
    task automatic count_release(input int start, output int n);
        n = start;
        while (!sys_rst_n && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b1; ext_rst_n = 1'b1;
        sw_raw = 4'hF; led_src = 8'h00;
        wr_en = 1'b0; wr_addr = 4'h0; wr_data = '0;
        tick(); tick();
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL rst_sys_rst_n: got %b expected 0", sys_rst_n); end
        checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL rst_led_out: got %h expected 00", led_out); end
        checks++; if (sw_db !== 4'h0) begin errors++; $display("FAIL rst_sw_db: got %h expected 0", sw_db); end
        checks++; if (sw_press !== 4'h0) begin errors++; $display("FAIL rst_sw_press: got %h expected 0", sw_press); end
    endtask

    task automatic test_rst_seq();
        int n;
        // clean release
        rst = 1'b0;
        tick();
        checks++; if (led_out !== 8'hFF) begin errors++; $display("FAIL lamp_test: got %h expected ff", led_out); end
        count_release(1, n);
        checks++; if (n !== 18) begin errors++; $display("FAIL release_edges: got %0d expected 18", n); end
        // lock dropout late in the hold window restarts the count
        pulse_rst();
        n = 0;
        repeat (15) begin tick(); n++; end
        pll_locked = 1'b0;
        tick(); n++;
        pll_locked = 1'b1;
        count_release(n, n);
        checks++; if (n !== 34) begin errors++; $display("FAIL delayed_release: got %0d expected 34", n); end
        // pin drop while running
        ext_rst_n = 1'b0;
        n = 0;
        while (sys_rst_n && n < 20) begin tick(); n++; end
        checks++; if (n !== 3) begin errors++; $display("FAIL run_to_hold: got %0d expected 3", n); end
        ext_rst_n = 1'b1;
        count_release(0, n);
        checks++; if (n !== 18) begin errors++; $display("FAIL rerelease: got %0d expected 18", n); end
    endtask

    task automatic test_debounce();
        int n, presses;
        logic changed;
        sw_raw[0] = 1'b0;
        n = 0; presses = 0;
        while (!sw_db[0] && n < 40) begin tick(); n++; presses += int'(sw_press[0]); end
        checks++; if (n !== 18) begin errors++; $display("FAIL db_press_edges: got %0d expected 18", n); end
        checks++; if (sw_press[0] !== 1'b1) begin errors++; $display("FAIL press_pulse_align: got %b expected 1", sw_press[0]); end
        repeat (5) begin tick(); presses += int'(sw_press[0]); end
        checks++; if (presses !== 1) begin errors++; $display("FAIL press_count: got %0d expected 1", presses); end
        // 10-clock glitch toward release
        presses = 0; changed = 1'b0;
        sw_raw[0] = 1'b1;
        repeat (10) begin tick(); presses += int'(sw_press[0]); changed |= ~sw_db[0]; end
        sw_raw[0] = 1'b0;
        repeat (30) begin tick(); presses += int'(sw_press[0]); changed |= ~sw_db[0]; end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL glitch_db: got changed=%b expected 0", changed); end
        checks++; if (presses !== 0) begin errors++; $display("FAIL glitch_press: got %0d expected 0", presses); end
        // release
        sw_raw[0] = 1'b1;
        n = 0; presses = 0;
        while (sw_db[0] && n < 40) begin tick(); n++; presses += int'(sw_press[0]); end
        repeat (3) begin tick(); presses += int'(sw_press[0]); end
        checks++; if (n !== 18) begin errors++; $display("FAIL db_release_edges: got %0d expected 18", n); end
        checks++; if (presses !== 0) begin errors++; $display("FAIL release_press: got %0d expected 0", presses); end
        checks++; if (sw_db !== 4'h0) begin errors++; $display("FAIL other_channels: got %h expected 0", sw_db); end
    endtask

    task automatic test_direct();
        int bad;
        led_src = 8'h3C;
        cfg_write(4'd5, 2'd0, 8'd0);
        tick();
        checks++; if (led_out !== 8'h3C) begin errors++; $display("FAIL direct_all: got %h expected 3c", led_out); end
        led_src[5] = 1'b0;
        checks++; if (led_out[5] !== 1'b1) begin errors++; $display("FAIL direct_before_edge: got %b expected 1", led_out[5]); end
        tick();
        checks++; if (led_out[5] !== 1'b0) begin errors++; $display("FAIL direct_follow: got %b expected 0", led_out[5]); end
        led_src = 8'hFF;
        cfg_write(4'd12, 2'd1, 8'd0);
        tick(); tick();
        bad = 0;
        repeat (16) begin tick(); if (led_out !== 8'hFF) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL addr12_ignored: got %0d bad samples expected 0", bad); end
    endtask

    task automatic test_pwm();
        int cnt;
        cfg_write(4'd2, 2'd1, 8'd64);
        tick(); tick();
        cnt = 0; repeat (256) begin tick(); cnt += int'(led_out[2]); end
        checks++; if (cnt !== 64) begin errors++; $display("FAIL pwm_duty64: got %0d expected 64", cnt); end
        cfg_write(4'd2, 2'd1, 8'd0);
        tick(); tick();
        cnt = 0; repeat (256) begin tick(); cnt += int'(led_out[2]); end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL pwm_duty0: got %0d expected 0", cnt); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        wr_en = 1'b1; wr_addr = 4'd2;
        wr_data = {2'd1, 8'd0};
        tick();
        wr_data = {2'd1, 8'd255};
        tick();
        wr_en = 1'b0;
        tick(); tick();
        cnt = 0; repeat (256) begin tick(); cnt += int'(led_out[2]); end
        checks++; if (cnt !== 255) begin errors++; $display("FAIL pwm_duty255_last_wins: got %0d expected 255", cnt); end
    endtask

    task automatic test_blink_pwm();
        int cnt, run, maxrun;
        cfg_write(4'd1, 2'd3, 8'd128);
        tick(); tick();
        cnt = 0; run = 0; maxrun = 0;
        repeat (512) begin
            tick();
            if (led_out[1]) begin cnt++; run++; if (run > maxrun) maxrun = run; end
            else run = 0;
        end
        checks++; if (cnt !== 128) begin errors++; $display("FAIL blink_pwm_count: got %0d expected 128", cnt); end
        checks++; if (maxrun !== 32) begin errors++; $display("FAIL blink_pwm_burst: got %0d expected 32", maxrun); end
        cfg_write(4'd1, 2'd2, 8'd0);
        tick(); tick();
        cnt = 0; repeat (256) begin tick(); cnt += int'(led_out[1]); end
        checks++; if (cnt !== 128) begin errors++; $display("FAIL blink_count: got %0d expected 128", cnt); end
    endtask

    task automatic test_mid_reset();
        int n;
        sw_raw[1] = 1'b0;
        repeat (25) tick();
        checks++; if (sw_db[1] !== 1'b1) begin errors++; $display("FAIL pre_rst_sw_db: got %b expected 1", sw_db[1]); end
        #3 rst = 1'b1;
        #1;
        checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL async_led_out: got %h expected 00", led_out); end
        checks++; if (sw_db !== 4'h0) begin errors++; $display("FAIL async_sw_db: got %h expected 0", sw_db); end
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL async_sys_rst_n: got %b expected 0", sys_rst_n); end
        tick(); tick();
        rst = 1'b0;
        led_src = 8'hA5;
        tick();
        checks++; if (led_out !== 8'hFF) begin errors++; $display("FAIL lamp_after_rst: got %h expected ff", led_out); end
        count_release(1, n);
        checks++; if (n !== 18) begin errors++; $display("FAIL mid_rst_release: got %0d expected 18", n); end
        checks++; if (sw_db[1] !== 1'b1) begin errors++; $display("FAIL db_during_hold: got %b expected 1", sw_db[1]); end
        tick();
        checks++; if (led_out !== 8'hA5) begin errors++; $display("FAIL modes_direct_after_rst: got %h expected a5", led_out); end
        sw_raw[1] = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rst_seq();
        test_debounce();
        test_direct();
        test_pwm();
        test_back_to_back();
        test_blink_pwm();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
